// File: rtl/tensor_tile_buf.sv
// Ping-pong A/B tile buffer: loads cfg_beats A rows then B rows per bank, drains paired rows. Optional stats via TILE_BUF_STATS_EN.
// First pair valid one edge after the bank-full edge; s_ready drops while the write bank is full, output held under m_ready=0.
module tensor_tile_buf #(
   parameter  int DATA_W = 256,
   parameter  int DEPTH  = 16,
   localparam int CNT_W  = $clog2(DEPTH) + 1,
   localparam int IDX_W  = $clog2(DEPTH)
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [CNT_W-1:0]  cfg_beats,
   input  logic              cfg_start,
   input  logic [DATA_W-1:0] s_dat,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_a_dat,
   output logic [DATA_W-1:0] m_b_dat,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic [1:0]        bank_full,
   output logic              busy
`ifdef TILE_BUF_STATS_EN
   ,
   output logic [15:0]       stat_tiles,
   output logic [15:0]       stat_stall
`endif
);

   typedef enum logic {LOAD_A = 1'b0, LOAD_B = 1'b1} phase_e;

   phase_e            phase_q, phase_d;
   logic [CNT_W-1:0]  beats_q, beats_d;
   logic [1:0]        bank_full_q, bank_full_d;
   logic              wr_bank_q, wr_bank_d;
   logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
   logic              rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
   logic              out_vld_q, out_vld_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] mem_a_q [2][DEPTH];
   logic [DATA_W-1:0] mem_a_d [2][DEPTH];
   logic [DATA_W-1:0] mem_b_q [2][DEPTH];
   logic [DATA_W-1:0] mem_b_d [2][DEPTH];

   logic              wr_en, wr_last, last_hs, src_bank, ld;
   logic [CNT_W-1:0]  src_idx;

   assign wr_last  = (wr_idx_q == beats_q - CNT_W'(1));
   assign last_hs  = out_vld_q && m_ready && last_q;
   // On the final handshake of a tile, look ahead into the other bank so tiles stream without a bubble.
   assign src_bank = last_hs ? ~rd_bank_q : rd_bank_q;
   assign src_idx  = last_hs ? '0 : rd_idx_q;
   assign ld       = (!out_vld_q || m_ready) && bank_full_q[src_bank] && (src_idx < beats_q);

   // Write FSM: outputs
   always_comb begin
      s_ready = (beats_q != '0) && !bank_full_q[wr_bank_q] && !cfg_start;
      wr_en   = s_valid && s_ready;
   end

   // Write FSM: next state
   always_comb begin
      phase_d = phase_q;
      if (cfg_start)
         phase_d = LOAD_A;
      else if (wr_en && wr_last)
         phase_d = (phase_q == LOAD_A) ? LOAD_B : LOAD_A;
   end

   always_comb begin
      beats_d     = beats_q;
      bank_full_d = bank_full_q;
      wr_bank_d   = wr_bank_q;
      wr_idx_d    = wr_idx_q;
      rd_bank_d   = rd_bank_q;
      rd_idx_d    = rd_idx_q;
      out_vld_d   = out_vld_q;
      last_d      = last_q;
      a_d         = a_q;
      b_d         = b_q;
      mem_a_d     = mem_a_q;
      mem_b_d     = mem_b_q;

      if (wr_en) begin
         if (phase_q == LOAD_A)
            mem_a_d[wr_bank_q][wr_idx_q[IDX_W-1:0]] = s_dat;
         else
            mem_b_d[wr_bank_q][wr_idx_q[IDX_W-1:0]] = s_dat;
         if (wr_last) begin
            wr_idx_d = '0;
            if (phase_q == LOAD_B) begin
               bank_full_d[wr_bank_q] = 1'b1;
               wr_bank_d              = ~wr_bank_q;
            end
         end else begin
            wr_idx_d = wr_idx_q + CNT_W'(1);
         end
      end

      if (last_hs) begin
         bank_full_d[rd_bank_q] = 1'b0;
         rd_bank_d              = src_bank;
         rd_idx_d               = '0;
      end

      if (ld) begin
         a_d       = mem_a_q[src_bank][src_idx[IDX_W-1:0]];
         b_d       = mem_b_q[src_bank][src_idx[IDX_W-1:0]];
         last_d    = (src_idx == beats_q - CNT_W'(1));
         out_vld_d = 1'b1;
         rd_idx_d  = src_idx + CNT_W'(1);
      end else if (out_vld_q && m_ready) begin
         out_vld_d = 1'b0;
      end

      // Flush wins over any same-cycle handshake.
      if (cfg_start) begin
         beats_d     = (cfg_beats > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_beats;
         bank_full_d = '0;
         wr_bank_d   = 1'b0;
         wr_idx_d    = '0;
         rd_bank_d   = 1'b0;
         rd_idx_d    = '0;
         out_vld_d   = 1'b0;
         last_d      = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase_q     <= LOAD_A;
         beats_q     <= '0;
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         rd_bank_q   <= 1'b0;
         rd_idx_q    <= '0;
         out_vld_q   <= 1'b0;
         last_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
      end else begin
         phase_q     <= phase_d;
         beats_q     <= beats_d;
         bank_full_q <= bank_full_d;
         wr_bank_q   <= wr_bank_d;
         wr_idx_q    <= wr_idx_d;
         rd_bank_q   <= rd_bank_d;
         rd_idx_q    <= rd_idx_d;
         out_vld_q   <= out_vld_d;
         last_q      <= last_d;
         a_q         <= a_d;
         b_q         <= b_d;
      end
   end

   // Row storage needs no reset: contents are only read from banks marked full.
   always_ff @(posedge aclk) begin
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
   end

   assign m_a_dat   = a_q;
   assign m_b_dat   = b_q;
   assign m_valid   = out_vld_q;
   assign m_last    = out_vld_q && last_q;
   assign bank_full = bank_full_q;
   assign busy      = (|bank_full_q) || (wr_idx_q != '0) || (phase_q == LOAD_B) || out_vld_q;

`ifdef TILE_BUF_STATS_EN
   logic [15:0] stat_tiles_q, stat_tiles_d;
   logic [15:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_tiles_d = stat_tiles_q;
      stat_stall_d = stat_stall_q;
      if (last_hs && stat_tiles_q != 16'hFFFF)
         stat_tiles_d = stat_tiles_q + 16'd1;
      if (s_valid && !s_ready && stat_stall_q != 16'hFFFF)
         stat_stall_d = stat_stall_q + 16'd1;
      if (cfg_start) begin
         stat_tiles_d = '0;
         stat_stall_d = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_tiles_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_tiles_q <= stat_tiles_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_tiles = stat_tiles_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_tensor_tile_buf.sv
// Directed bench for tensor_tile_buf: vector table for the basic tile, hand sequences for the corner cases.
module tb_tensor_tile_buf;
   localparam int DATA_W = 256;
   localparam int CNT_W  = 5;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [CNT_W-1:0]  cfg_beats;
   logic              cfg_start;
   logic [DATA_W-1:0] s_dat;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] m_a_dat, m_b_dat;
   logic              m_valid, m_ready, m_last;
   logic [1:0]        bank_full;
   logic              busy;
`ifdef TILE_BUF_STATS_EN
   logic [15:0]       stat_tiles, stat_stall;
`endif

   int checks   = 0;
   int failures = 0;

   tensor_tile_buf #(.DATA_W(DATA_W), .DEPTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn), .cfg_beats(cfg_beats), .cfg_start(cfg_start),
      .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
      .m_a_dat(m_a_dat), .m_b_dat(m_b_dat), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .bank_full(bank_full), .busy(busy)
`ifdef TILE_BUF_STATS_EN
      , .stat_tiles(stat_tiles), .stat_stall(stat_stall)
`endif
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic       start;
      logic [4:0] beats;
      logic       sv;
      logic [7:0] sd;
      logic       mr;
      logic       e_srdy;
      logic       e_mv;
      logic [7:0] e_a;
      logic [7:0] e_b;
      logic       e_last;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge, returns at the next negedge.
   task automatic do_start(input int b);
      cfg_start = 1'b1;
      cfg_beats = 5'(b);
      s_valid   = 1'b0;
      #1;
      chk("start s_ready", s_ready, 0);
      @(negedge aclk);
      cfg_start = 1'b0;
   endtask

   // Streams ntiles tiles of nb rows/operand and scoreboards the pairs.
   task automatic run_tiles(input int nb, input int ntiles, input int base, input bit rnd);
      int total_beats = 2 * nb * ntiles;
      int total_pairs = nb * ntiles;
      int pushed = 0, got = 0, cyc = 0, t, j, ea;
      bit prev_stall = 0;
      logic [255:0] pa = '0, pb = '0;
      logic pl = 1'b0;
      while (got < total_pairs && cyc < total_beats * 6 + 100) begin
         s_valid = (pushed < total_beats) && (!rnd || $urandom_range(0, 3) != 0);
         s_dat   = 256'(base + pushed);
         m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         if (prev_stall) begin
            chk("stall m_valid", m_valid, 1);
            chk("stall a", m_a_dat, pa);
            chk("stall b", m_b_dat, pb);
            chk("stall last", m_last, pl);
         end
         if (s_valid && s_ready) pushed++;
         if (m_valid && m_ready) begin
            t  = got / nb;
            j  = got % nb;
            ea = base + t * 2 * nb + j;
            chk("pair a", m_a_dat, ea);
            chk("pair b", m_b_dat, ea + nb);
            chk("pair last", m_last, (j == nb - 1));
            got++;
         end
         prev_stall = m_valid && !m_ready;
         pa = m_a_dat; pb = m_b_dat; pl = m_last;
         @(negedge aclk);
         cyc++;
      end
      chk("pairs received", got, total_pairs);
      s_valid = 1'b0;
      m_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cyc;
      logic [255:0] ea;

      tv[0] = '{1'b1, 5'd4, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0};
      for (int i = 1; i <= 8; i++)
         tv[i] = '{1'b0, 5'd4, 1'b1, 8'(i - 1), 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
      tv[9]  = '{1'b0, 5'd4, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};
      for (int i = 0; i < 4; i++)
         tv[10 + i] = '{1'b0, 5'd4, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'(i), 8'(i + 4), (i == 3)};
      tv[14] = '{1'b0, 5'd4, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0};

      aresetn = 1'b1; cfg_start = 1'b0; cfg_beats = '0; s_valid = 1'b0; s_dat = '0; m_ready = 1'b0;
      #2 aresetn = 1'b0;
      @(negedge aclk);
      #1;
      chk("rst s_ready", s_ready, 0);
      chk("rst m_valid", m_valid, 0);
      chk("rst bank_full", bank_full, 0);
      chk("rst busy", busy, 0);
      chk("rst m_a_dat", m_a_dat, 0);
      chk("rst m_last", m_last, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      // Basic tile, cycle-by-cycle
      for (int i = 0; i < 15; i++) begin
         cfg_start = tv[i].start;
         cfg_beats = tv[i].beats;
         s_valid   = tv[i].sv;
         s_dat     = 256'(tv[i].sd);
         m_ready   = tv[i].mr;
         #1;
         chk($sformatf("t1[%0d] s_ready", i), s_ready, tv[i].e_srdy);
         chk($sformatf("t1[%0d] m_valid", i), m_valid, tv[i].e_mv);
         chk($sformatf("t1[%0d] m_last", i), m_last, tv[i].e_last);
         if (tv[i].e_mv) begin
            chk($sformatf("t1[%0d] a", i), m_a_dat, tv[i].e_a);
            chk($sformatf("t1[%0d] b", i), m_b_dat, tv[i].e_b);
         end
         @(negedge aclk);
      end
      cfg_start = 1'b0; s_valid = 1'b0;

      // Both banks filled under stall, then back-to-back drain
      do_start(4);
      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1;
         s_dat   = 256'(100 + i);
         #1;
         chk("t2 fill s_ready", s_ready, 1);
         @(negedge aclk);
      end
      s_dat = 256'(200);
      #1;
      chk("t2 full s_ready", s_ready, 0);
      chk("t2 bank_full", bank_full, 2'b11);
      chk("t2 held m_valid", m_valid, 1);
      @(negedge aclk);
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         #1;
         ea = (j < 4) ? 256'(100 + j) : 256'(104 + j);
         chk("t2 drain m_valid", m_valid, 1);
         chk("t2 drain a", m_a_dat, ea);
         chk("t2 drain b", m_b_dat, ea + 4);
         chk("t2 drain last", m_last, (j == 3 || j == 7));
         chk("t2 drain s_ready", s_ready, (j >= 4));
         @(negedge aclk);
      end
      #1;
      chk("t2 end m_valid", m_valid, 0);
      chk("t2 end bank_full", bank_full, 0);
      @(negedge aclk);
      m_ready = 1'b0;

      // Random backpressure over many tiles
      do_start(4);
      run_tiles(4, 100, 1000, 1'b1);
      #1;
      chk("t3 idle busy", busy, 0);
      @(negedge aclk);

      // Flush a partial load and reconfigure
      do_start(4);
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_dat   = 256'(20 + i);
         #1;
         chk("t4 partial s_ready", s_ready, 1);
         @(negedge aclk);
      end
      #1;
      chk("t4 partial busy", busy, 1);
      cfg_start = 1'b1;
      cfg_beats = 5'd2;
      s_dat     = 256'(99);
      #1;
      chk("t4 start s_ready", s_ready, 0);
      @(negedge aclk);
      cfg_start = 1'b0;
      s_valid   = 1'b0;
      #1;
      chk("t4 flush bank_full", bank_full, 0);
      chk("t4 flush m_valid", m_valid, 0);
      chk("t4 flush busy", busy, 0);
      @(negedge aclk);
      run_tiles(2, 1, 10, 1'b0);

      // Async reset mid-drain
      do_start(4);
      m_ready = 1'b0;
      n = 0; cyc = 0;
      while (n < 8 && cyc < 50) begin
         s_valid = 1'b1;
         s_dat   = 256'(n);
         #1;
         if (s_ready) n++;
         @(negedge aclk);
         cyc++;
      end
      s_valid = 1'b0;
      cyc = 0;
      #1;
      while (!m_valid && cyc < 10) begin
         @(negedge aclk);
         #1;
         cyc++;
      end
      chk("t5 pre-reset m_valid", m_valid, 1);
      aresetn = 1'b0;
      #1;
      chk("t5 rst m_valid", m_valid, 0);
      chk("t5 rst s_ready", s_ready, 0);
      chk("t5 rst bank_full", bank_full, 0);
      chk("t5 rst busy", busy, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      // Zero beats blocks input; oversize beats clamp to DEPTH
      do_start(0);
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_dat   = 256'(50 + i);
         #1;
         chk("t6 zero s_ready", s_ready, 0);
         @(negedge aclk);
      end
      s_valid = 1'b0;
`ifdef TILE_BUF_STATS_EN
      #1;
      chk("t6 stat_stall", stat_stall, 5);
      @(negedge aclk);
`endif
      do_start(20);
      run_tiles(16, 1, 300, 1'b0);
`ifdef TILE_BUF_STATS_EN
      #1;
      chk("t6 stat_tiles", stat_tiles, 1);
      chk("t6 stat_stall clr", stat_stall, 0);
      @(negedge aclk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
